// File: rtl/parity_arq_channel_if.sv
// Word-level handshake between producer, parity ARQ channel and consumer.
// master: producer/consumer side; slave: the channel itself.
interface parity_arq_channel_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_RETRIES = 3
);
    localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [DATA_WIDTH:0]   inject_mask;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  error_detected;
    logic                  drop;
    logic [RC_W-1:0]       retry_count;
    logic                  busy;

    modport master (
        output tx_valid, tx_data, inject_mask,
        input  tx_ready, rx_valid, rx_data, error_detected, drop, retry_count, busy
    );

    modport slave (
        input  tx_valid, tx_data, inject_mask,
        output tx_ready, rx_valid, rx_data, error_detected, drop, retry_count, busy
    );
endinterface

// File: rtl/parity_arq_channel.sv
// Parity-framed serial channel with per-bit error injection and automatic
// retransmission. A word is framed with one parity bit, shifted one bit per
// clock through the faulty wire, checked, and either delivered, retried or
// dropped once the retry budget is spent.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a word; tx_ready high
// S_SEND  | shifting frame bit bit_cnt (data LSB first, parity last)
// S_CHECK | parity check of the received frame; deliver, retry or drop
module parity_arq_channel #(
    parameter int DATA_WIDTH  = 8,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int MAX_RETRIES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    parity_arq_channel_if.slave  ch
);
    localparam int FW    = DATA_WIDTH + 1;
    localparam int CNT_W = (FW > 2) ? $clog2(FW) : 1;
    localparam int RC_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [FW-1:0]         mask_q;
    logic [FW-1:0]         rx_shift;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  err_q;
    logic                  drop_q;
    logic [RC_W-1:0]       retry_q;

    logic [FW-1:0]         frame;
    logic                  wire_bit;
    logic                  last_bit;
    logic                  rx_ok;
    logic                  retries_left;

    // Frame the held word, apply the injected fault to the bit on the wire,
    // and evaluate the receiver-side parity check.
    always_comb begin
        frame        = {(^data_q) ^ PARITY_ODD, data_q};
        wire_bit     = frame[bit_cnt] ^ mask_q[bit_cnt];
        last_bit     = (bit_cnt == CNT_W'(DATA_WIDTH));
        rx_ok        = ((^rx_shift) == PARITY_ODD);
        retries_left = (retry_q != RC_W'(MAX_RETRIES));
    end

    // Sequencer: accept a word, serialise it, check parity, then deliver,
    // retransmit with a freshly sampled mask, or drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            retry_q    <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ch.tx_valid) begin
                        data_q  <= ch.tx_data;
                        mask_q  <= ch.inject_mask;
                        retry_q <= '0;
                        bit_cnt <= '0;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Bit 0 is sent first and ends up at rx_shift[0] after FW shifts.
                    rx_shift <= {wire_bit, rx_shift[FW-1:1]};
                    if (last_bit) begin
                        bit_cnt <= '0;
                        state   <= S_CHECK;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (rx_ok) begin
                        // Even-weight faults land here too and are delivered as-is.
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_shift[DATA_WIDTH-1:0];
                        state      <= S_IDLE;
                    end else begin
                        err_q <= 1'b1;
                        if (retries_left) begin
                            retry_q <= retry_q + 1'b1;
                            mask_q  <= ch.inject_mask;
                            state   <= S_SEND;
                        end else begin
                            drop_q <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ch.tx_ready       = (state == S_IDLE);
    assign ch.busy           = (state == S_SEND) || (state == S_CHECK);
    assign ch.rx_valid       = rx_valid_q;
    assign ch.rx_data        = rx_data_q;
    assign ch.error_detected = err_q;
    assign ch.drop           = drop_q;
    assign ch.retry_count    = retry_q;
endmodule

// File: tb/tb_parity_arq_channel.sv
// Bench for parity_arq_channel: three configurations (W=8 even/3 retries,
// W=16 odd/3 retries, W=16 odd/0 retries). A timeline model predicts every
// output on every cycle; directed words add literal expectations.
module tb_parity_arq_channel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int sel  = 0;
    int cw   = 8;
    int codd = 0;
    int cmax = 3;

    logic        tb_valid = 1'b0;
    logic [15:0] tb_data  = 16'h0;
    logic [16:0] tb_mask  = 17'h0;
    logic [16:0] mk [0:7];

    parity_arq_channel_if #(.DATA_WIDTH(8),  .MAX_RETRIES(3)) if_a ();
    parity_arq_channel_if #(.DATA_WIDTH(16), .MAX_RETRIES(3)) if_b ();
    parity_arq_channel_if #(.DATA_WIDTH(16), .MAX_RETRIES(0)) if_c ();

    assign if_a.tx_valid    = tb_valid && (sel == 0);
    assign if_a.tx_data     = tb_data[7:0];
    assign if_a.inject_mask = tb_mask[8:0];
    assign if_b.tx_valid    = tb_valid && (sel == 1);
    assign if_b.tx_data     = tb_data;
    assign if_b.inject_mask = tb_mask;
    assign if_c.tx_valid    = tb_valid && (sel == 2);
    assign if_c.tx_data     = tb_data;
    assign if_c.inject_mask = tb_mask;

    parity_arq_channel #(.DATA_WIDTH(8),  .PARITY_ODD(1'b0), .MAX_RETRIES(3))
        dut_a (.clk(clk), .rst(rst), .ch(if_a));
    parity_arq_channel #(.DATA_WIDTH(16), .PARITY_ODD(1'b1), .MAX_RETRIES(3))
        dut_b (.clk(clk), .rst(rst), .ch(if_b));
    parity_arq_channel #(.DATA_WIDTH(16), .PARITY_ODD(1'b1), .MAX_RETRIES(0))
        dut_c (.clk(clk), .rst(rst), .ch(if_c));

    logic        o_ready, o_busy, o_rxv, o_err, o_drop;
    logic [15:0] o_rxd;
    logic [3:0]  o_retry;

    always_comb begin
        o_ready = if_a.tx_ready;
        o_busy  = if_a.busy;
        o_rxv   = if_a.rx_valid;
        o_err   = if_a.error_detected;
        o_drop  = if_a.drop;
        o_rxd   = {8'h00, if_a.rx_data};
        o_retry = {2'b00, if_a.retry_count};
        if (sel == 1) begin
            o_ready = if_b.tx_ready;
            o_busy  = if_b.busy;
            o_rxv   = if_b.rx_valid;
            o_err   = if_b.error_detected;
            o_drop  = if_b.drop;
            o_rxd   = if_b.rx_data;
            o_retry = {2'b00, if_b.retry_count};
        end else if (sel == 2) begin
            o_ready = if_c.tx_ready;
            o_busy  = if_c.busy;
            o_rxv   = if_c.rx_valid;
            o_err   = if_c.error_detected;
            o_drop  = if_c.drop;
            o_rxd   = if_c.rx_data;
            o_retry = {3'b000, if_c.retry_count};
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: edges since acceptance (m_c), edge of the final result (m_end),
    // outcome of the word, and per-DUT held rx_data / retry_count.
    int          m_c     = 0;
    int          m_end   = 0;
    int          m_final = 0;
    bit          m_act   = 1'b0;
    bit          m_pass  = 1'b0;
    logic [15:0] m_recv  = 16'h0;
    logic [15:0] m_rxd [0:2];
    int          m_ret [0:2];

    task automatic predict(input logic [15:0] d);
        logic [16:0] dmask, fmask, fr, rcv;
        dmask = 17'((1 << cw) - 1);
        fmask = 17'((1 << (cw + 1)) - 1);
        fr = {1'b0, d} & dmask;
        fr[cw] = 1'($countones(fr) % 2) ^ 1'(codd);
        m_pass  = 1'b0;
        m_final = cmax;
        m_recv  = 16'h0;
        for (int a = 0; a <= cmax; a++) begin
            rcv = (fr ^ mk[a]) & fmask;
            if (($countones(rcv) % 2) == codd) begin
                m_pass  = 1'b1;
                m_final = a;
                m_recv  = rcv[15:0] & dmask[15:0];
                break;
            end
        end
        m_end = (m_final + 1) * (cw + 2);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_rxd[i] = 16'h0;
            m_ret[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_act = 1'b0;
                m_c   = 0;
                m_end = 0;
                for (int i = 0; i < 3; i++) begin
                    m_rxd[i] = 16'h0;
                    m_ret[i] = 0;
                end
            end else if (tb_valid && !(m_act && m_c < m_end)) begin
                predict(tb_data);
                m_act      = 1'b1;
                m_c        = 0;
                m_ret[sel] = 0;
            end else if (m_act) begin
                m_c++;
                if (m_c == m_end) begin
                    if (m_pass) m_rxd[sel] = m_recv;
                    m_ret[sel] = m_pass ? m_final : cmax;
                end
            end
        end
    end

    // Per-cycle compare of all outputs against the model; also records the
    // cycle (acceptance = 0) of the first rx_valid / error / drop of a word.
    int rec_rx = 0, rec_err = 0, rec_drop = 0, n_err = 0;
    initial begin
        int k;
        bit e_busy, e_rxv, e_err, e_drop;
        int e_ret;
        forever begin
            @(negedge clk);
            if (!rst) begin
                k      = m_c;
                e_busy = m_act && (k < m_end);
                e_rxv  = m_act && (k == m_end) && m_pass;
                e_drop = m_act && (k == m_end) && !m_pass;
                e_err  = m_act && (k > 0) && (k <= m_end) && ((k % (cw + 2)) == 0) && !e_rxv;
                e_ret  = e_busy ? (k / (cw + 2)) : m_ret[sel];
                chk("tx_ready",    32'(o_ready), 32'(!e_busy));
                chk("busy",        32'(o_busy),  32'(e_busy));
                chk("rx_valid",    32'(o_rxv),   32'(e_rxv));
                chk("error_det",   32'(o_err),   32'(e_err));
                chk("drop",        32'(o_drop),  32'(e_drop));
                chk("retry_count", 32'(o_retry), 32'(e_ret));
                chk("rx_data",     32'(o_rxd),   32'(m_rxd[sel]));
                if (o_rxv && rec_rx == 0) rec_rx = k + 1;
                if (o_err) begin
                    n_err++;
                    if (rec_err == 0) rec_err = k + 1;
                end
                if (o_drop && rec_drop == 0) rec_drop = k + 1;
            end
        end
    end

    task automatic set_mk(input logic [16:0] first, input logic [16:0] rest);
        mk[0] = first;
        for (int i = 1; i < 8; i++) mk[i] = rest;
    endtask

    task automatic run_word(input logic [15:0] d);
        int guard;
        rec_rx = 0; rec_err = 0; rec_drop = 0; n_err = 0;
        @(negedge clk);
        tb_valid = 1'b1;
        tb_data  = d;
        tb_mask  = mk[0];
        @(posedge clk);
        #1 tb_valid = 1'b0;
        guard = 0;
        while (m_c < m_end && guard < 400) begin
            @(negedge clk);
            guard++;
            if (((m_c + 1) % (cw + 2)) == 0 && ((m_c + 1) / (cw + 2)) < 8)
                tb_mask = mk[(m_c + 1) / (cw + 2)];
        end
        chk("word_timeout", 32'(guard >= 400), 32'(0));
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        set_mk(17'h0, 17'h0);
        repeat (2) @(negedge clk);
        chk("rst_tx_ready", 32'(o_ready), 32'(1));
        chk("rst_busy",     32'(o_busy),  32'(0));
        chk("rst_rx_valid", 32'(o_rxv),   32'(0));
        chk("rst_rx_data",  32'(o_rxd),   32'(0));
        chk("rst_retry",    32'(o_retry), 32'(0));
        rst = 1'b0;

        // Clean delivery
        set_mk(17'h0, 17'h0);
        run_word(16'h00AA);
        chk("t1_rx_cycle", 32'(rec_rx),  32'(11));
        chk("t1_rx_data",  32'(o_rxd),   32'h00AA);
        chk("t1_retry",    32'(o_retry), 32'(0));
        chk("t1_errors",   32'(n_err),   32'(0));

        // One failed attempt, then clean retransmission
        set_mk(17'h001, 17'h0);
        run_word(16'h00CC);
        chk("t2_err_cycle", 32'(rec_err), 32'(11));
        chk("t2_rx_cycle",  32'(rec_rx),  32'(21));
        chk("t2_rx_data",   32'(o_rxd),   32'h00CC);
        chk("t2_retry",     32'(o_retry), 32'(1));

        // Persistent parity-bit fault: retries exhausted, word dropped
        set_mk(17'h100, 17'h100);
        run_word(16'h0055);
        chk("t3_err_first", 32'(rec_err),  32'(11));
        chk("t3_err_count", 32'(n_err),    32'(4));
        chk("t3_drop_cyc",  32'(rec_drop), 32'(41));
        chk("t3_no_rx",     32'(rec_rx),   32'(0));
        chk("t3_retry",     32'(o_retry),  32'(3));
        chk("t3_rx_held",   32'(o_rxd),    32'h00CC);

        // Even-weight fault escapes detection
        set_mk(17'h003, 17'h0);
        run_word(16'h00E0);
        chk("t4_rx_cycle", 32'(rec_rx), 32'(11));
        chk("t4_rx_data",  32'(o_rxd),  32'h00E3);
        chk("t4_errors",   32'(n_err),  32'(0));

        // Reset in the middle of SEND aborts the frame
        set_mk(17'h0, 17'h0);
        rec_rx = 0;
        @(negedge clk);
        tb_valid = 1'b1;
        tb_data  = 16'h0012;
        tb_mask  = 17'h0;
        @(posedge clk);
        #1 tb_valid = 1'b0;
        guard = 0;
        while (m_c < 4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("t5_busy_before", 32'(o_busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ready",  32'(o_ready), 32'(1));
        chk("t5_rst_busy",   32'(o_busy),  32'(0));
        chk("t5_rst_rxv",    32'(o_rxv),   32'(0));
        chk("t5_rst_err",    32'(o_err),   32'(0));
        chk("t5_rst_drop",   32'(o_drop),  32'(0));
        chk("t5_rst_rxdata", 32'(o_rxd),   32'(0));
        chk("t5_rst_retry",  32'(o_retry), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5_no_rx", 32'(rec_rx), 32'(0));
        run_word(16'h00FF);
        chk("t5_next_rx_cycle", 32'(rec_rx), 32'(11));
        chk("t5_next_rx_data",  32'(o_rxd),  32'h00FF);

        // W=16, odd parity, clean
        @(negedge clk);
        sel = 1; cw = 16; codd = 1; cmax = 3;
        set_mk(17'h0, 17'h0);
        run_word(16'hBEEF);
        chk("t6_rx_cycle", 32'(rec_rx), 32'(19));
        chk("t6_rx_data",  32'(o_rxd),  32'hBEEF);
        chk("t6_errors",   32'(n_err),  32'(0));

        // W=16, odd parity, no retries: single failure drops the word
        @(negedge clk);
        sel = 2; cw = 16; codd = 1; cmax = 0;
        set_mk(17'h10000, 17'h0);
        run_word(16'hBEEF);
        chk("t7_err_cycle",  32'(rec_err),  32'(19));
        chk("t7_drop_cycle", 32'(rec_drop), 32'(19));
        chk("t7_err_count",  32'(n_err),    32'(1));
        chk("t7_no_rx",      32'(rec_rx),   32'(0));
        chk("t7_retry",      32'(o_retry),  32'(0));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/parity_arq_channel.md
Name: parity_arq_channel

Overview:
Parametrised successor to the combinational parity transmission channel. It accepts a DATA_WIDTH-bit word and frames it with one parity bit. The frame is shifted serially, one bit per clock, across an internal channel with per-bit error injection. The receiver checks parity and requests automatic retransmission, up to MAX_RETRIES times, before dropping the word. It sits between a word producer and a consumer in the link test environment and gives error injection, detection and recovery a cycle-accurate model.

Parameters:
DATA_WIDTH, 8, payload width in bits (>=1)
PARITY_ODD, 0, 0 = even parity, 1 = odd parity
MAX_RETRIES, 3, retransmissions allowed after the first failed attempt (>=0)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  block can accept a word; high only in IDLE
tx_data  input  DATA_WIDTH  payload
inject_mask  input  DATA_WIDTH+1  bit i set flips frame bit i on the wire; bit DATA_WIDTH = parity bit
rx_valid  output  1  one-cycle pulse, rx_data valid
rx_data  output  DATA_WIDTH  received payload (parity stripped)
error_detected  output  1  one-cycle pulse per attempt that fails the parity check
drop  output  1  one-cycle pulse when retries are exhausted; the word is discarded
retry_count  output  max(1,$clog2(MAX_RETRIES+1))  retransmissions used for the current or last word
busy  output  1  high in SEND or CHECK

Behaviour:
- Reset (asynchronous, takes effect immediately, any state): state=IDLE, tx_ready=1, rx_valid=0, rx_data=0, error_detected=0, drop=0, retry_count=0, busy=0; all shift/count registers cleared.
- Reset mid-frame aborts the frame. No rx_valid or drop is produced for it.
- Frame: bits 0..W-1 = tx_data LSB first; bit W = parity. Even parity: parity=^data. Odd parity: parity=~^data. W denotes DATA_WIDTH.
- States: IDLE, SEND, CHECK.
- IDLE: tx_ready=1. On tx_valid&&tx_ready at an edge:
  - latch tx_data and inject_mask;
  - clear retry_count;
  - go to SEND with bit_cnt=0.
  tx_valid while not IDLE is ignored (tx_ready=0).
- SEND: W+1 cycles. Each cycle, frame[bit_cnt]^mask[bit_cnt] is shifted into the receive register and bit_cnt increments. After bit W the state goes to CHECK. bit_cnt wraps to 0 on exit.
- CHECK: one cycle. Pass condition: XOR over all W+1 received bits == PARITY_ODD.
  - Pass: at the exiting edge, rx_valid=1 for one cycle, rx_data=received bits 0..W-1, go to IDLE.
  - Fail with retry_count<MAX_RETRIES: error_detected=1 for one cycle, retry_count+1, re-latch inject_mask from the port, go to SEND retransmitting the held word.
  - Fail with retry_count==MAX_RETRIES: error_detected=1 and drop=1 in the same cycle, go to IDLE. retry_count is held.
- Latency: acceptance edge = cycle 0. The first-attempt result (rx_valid or error_detected) appears in cycle W+3. Each retransmission adds W+2 cycles.
- rx_data holds its value until the next rx_valid. retry_count holds until the next acceptance.
- An even-weight inject_mask escapes detection. rx_valid is then asserted with corrupted data. This is the required behaviour and is not flagged.
- MAX_RETRIES=0: a single attempt; a failure gives error_detected and drop together.
- Back-to-back: tx_ready is high in the cycle after rx_valid/drop, so a new word is accepted at that cycle's edge.

Test Plan:
- W=8, even parity, 0xAA, mask 0 -> rx_valid in cycle 11, rx_data=0xAA, retry_count=0, no error_detected.
- 0xCC, mask 9'h001 on the first attempt, 0 afterwards -> error_detected in cycle 11, rx_valid in cycle 21 with 0xCC, retry_count=1.
- 0x55, mask 9'h100 held constant, MAX_RETRIES=3 -> error_detected in cycles 11/21/31/41, drop in cycle 41, retry_count=3, no rx_valid.
- 0xE0, mask 9'h003 -> rx_valid in cycle 11 with rx_data=0xE3, error_detected never asserted (undetected double error).
- Reset asserted during cycle 5 of SEND -> all outputs 0 immediately, tx_ready=1 after release, no rx_valid. A next word 0xFF is delivered normally 11 cycles after acceptance.
- PARITY_ODD=1, W=16, 0xBEEF, mask 0 -> rx_valid in cycle 19, rx_data=0xBEEF. Same configuration with mask 17'h10000 and MAX_RETRIES=0 -> error_detected and drop together in cycle 19.
